// File: rtl/dac_serializer.sv
// Output stage: sample-rate tick generator, saturating 24-to-16-bit offset-binary
// conversion and MSB-first serial shifting to a 16-bit DAC (SCLK / SYNC_n / DIN).
module dac_serializer #(
    parameter int SAMPLE_DIV = 1000,
    parameter int SCLK_DIV   = 2,
    parameter int SHIFT      = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [23:0] i_sample,
    output logic        o_sample_tick,
    output logic [15:0] o_dac_word,
    output logic        o_dac_sclk,
    output logic        o_dac_sync_n,
    output logic        o_dac_din,
    output logic        o_busy,
    output logic        o_overrun
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] sample_cnt;
    logic [DW-1:0] div_cnt, div_n;
    logic [4:0]    half_cnt, half_n;
    logic [15:0]   shreg, shreg_n;
    logic [15:0]   word, word_n;
    logic          sclk, sclk_n;
    logic          sync_n, sync_n_n;
    logic          din, din_n;
    logic          busy, busy_n;
    logic          overrun, overrun_n;
    logic          tick;

    logic signed [23:0] shifted;
    logic        [15:0] clamped;
    logic        [15:0] code;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            sample_cnt <= '0;
        else if (sample_cnt == CW'(SAMPLE_DIV - 1))
            sample_cnt <= '0;
        else
            sample_cnt <= sample_cnt + CW'(1);
    end

    assign tick = (sample_cnt == CW'(SAMPLE_DIV - 1));

    assign shifted = $signed(i_sample) >>> SHIFT;

    always_comb begin
        if (shifted > 24'sd32767)
            clamped = 16'h7FFF;
        else if (shifted < -24'sd32768)
            clamped = 16'h8000;
        else
            clamped = shifted[15:0];
    end

    assign code = {~clamped[15], clamped[14:0]};

    // Each SCLK half-period is one half_cnt step; half 0 is the leading high phase
    // and the 16th falling edge enters half 31, after which the frame closes.
    always_comb begin
        state_n   = state;
        div_n     = div_cnt;
        half_n    = half_cnt;
        shreg_n   = shreg;
        word_n    = word;
        sclk_n    = sclk;
        sync_n_n  = sync_n;
        din_n     = din;
        busy_n    = busy;
        overrun_n = overrun;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_n  = ST_SHIFT;
                    word_n   = code;
                    shreg_n  = code;
                    din_n    = code[15];
                    sync_n_n = 1'b0;
                    busy_n   = 1'b1;
                    sclk_n   = 1'b1;
                    div_n    = '0;
                    half_n   = '0;
                end
            end
            ST_SHIFT: begin
                if (tick)
                    overrun_n = 1'b1;
                if (div_cnt == DW'(SCLK_DIV - 1)) begin
                    div_n = '0;
                    if (half_cnt == 5'd31) begin
                        state_n  = ST_IDLE;
                        sync_n_n = 1'b1;
                        busy_n   = 1'b0;
                        din_n    = 1'b0;
                        sclk_n   = 1'b1;
                    end else begin
                        half_n = half_cnt + 5'd1;
                        sclk_n = ~sclk;
                        if (!sclk) begin
                            shreg_n = {shreg[14:0], 1'b0};
                            din_n   = shreg[14];
                        end
                    end
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            half_cnt <= '0;
            shreg    <= '0;
            word     <= 16'h8000;
            sclk     <= 1'b1;
            sync_n   <= 1'b1;
            din      <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            half_cnt <= half_n;
            shreg    <= shreg_n;
            word     <= word_n;
            sclk     <= sclk_n;
            sync_n   <= sync_n_n;
            din      <= din_n;
            busy     <= busy_n;
            overrun  <= overrun_n;
        end
    end

    assign o_sample_tick = tick;
    assign o_dac_word    = word;
    assign o_dac_sclk    = sclk;
    assign o_dac_sync_n  = sync_n;
    assign o_dac_din     = din;
    assign o_busy        = busy;
    assign o_overrun     = overrun;

endmodule

// File: tb/tb_dac_serializer.sv
// Self-checking bench for dac_serializer: a normal-rate instance for conversion and
// framing, and a short-period instance that provokes overrun.
module tb_dac_serializer;

    typedef struct {
        logic [23:0] sample;
        logic [15:0] word;
    } vec_t;

    logic        clk;
    logic        reset1, reset2;
    logic [23:0] sample1, sample2;
    logic        tick1, tick2;
    logic [15:0] word1, word2;
    logic        sclk1, sclk2, syncN1, syncN2, din1, din2, busy1, busy2, ovr1, ovr2;
    logic        sel;
    logic        selTick, selSclk, selSyncN, selDin, selBusy, selOvr;
    logic [15:0] selWord;
    int          tests;
    int          failed;
    vec_t        vecs[9];

    dac_serializer #(.SAMPLE_DIV(100), .SCLK_DIV(2), .SHIFT(3)) dutMain (
        .i_clk(clk), .i_reset(reset1), .i_sample(sample1),
        .o_sample_tick(tick1), .o_dac_word(word1), .o_dac_sclk(sclk1),
        .o_dac_sync_n(syncN1), .o_dac_din(din1), .o_busy(busy1), .o_overrun(ovr1)
    );

    dac_serializer #(.SAMPLE_DIV(40), .SCLK_DIV(2), .SHIFT(3)) dutOvr (
        .i_clk(clk), .i_reset(reset2), .i_sample(sample2),
        .o_sample_tick(tick2), .o_dac_word(word2), .o_dac_sclk(sclk2),
        .o_dac_sync_n(syncN2), .o_dac_din(din2), .o_busy(busy2), .o_overrun(ovr2)
    );

    assign selTick  = sel ? tick2  : tick1;
    assign selSclk  = sel ? sclk2  : sclk1;
    assign selSyncN = sel ? syncN2 : syncN1;
    assign selDin   = sel ? din2   : din1;
    assign selBusy  = sel ? busy2  : busy1;
    assign selOvr   = sel ? ovr2   : ovr1;
    assign selWord  = sel ? word2  : word1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic setSample(input logic [23:0] s);
        if (sel) sample2 = s; else sample1 = s;
    endtask

    task automatic setReset(input logic r);
        if (sel) reset2 = r; else reset1 = r;
    endtask

    task automatic applyStimulus(input logic [23:0] s);
        @(negedge clk);
        setSample(s);
    endtask

    // Waits for SYNC_n to fall, then collects DIN on every SCLK falling edge until
    // SYNC_n rises; resetAt > 0 asserts reset after that many falling edges.
    task automatic captureFrame(input int resetAt, input logic [23:0] midSample,
                                output logic [15:0] bits, output int lowCycles,
                                output int waitCycles, output int tickAt, output bit timedOut);
        int   falls;
        logic prevSclk;
        bits = '0; lowCycles = 0; waitCycles = 0; tickAt = -1; timedOut = 0;
        falls = 0; prevSclk = 1'b1;
        do begin
            @(posedge clk); #1;
            waitCycles++;
            if (selTick && tickAt < 0) tickAt = waitCycles;
        end while (selSyncN && waitCycles < 400);
        if (selSyncN) begin
            timedOut = 1;
            return;
        end
        setSample(midSample);
        while (!selSyncN && lowCycles < 400) begin
            lowCycles++;
            if (prevSclk && !selSclk) begin
                if (falls < 16) bits[15 - falls] = selDin;
                falls++;
                if (falls == resetAt) begin
                    setReset(1'b1);
                    @(posedge clk); #1;
                    return;
                end
            end
            prevSclk = selSclk;
            @(posedge clk); #1;
        end
        if (!selSyncN) timedOut = 1;
    endtask

    initial begin
        logic [15:0] bits;
        int          lowCycles, waitCycles, tickAt;
        bit          timedOut;

        vecs[0] = '{24'h000000, 16'h8000};
        vecs[1] = '{24'h03FFF8, 16'hFFFF};
        vecs[2] = '{24'hFFFFF8, 16'h7FFF};
        vecs[3] = '{24'h000008, 16'h8001};
        vecs[4] = '{24'h7FFFFF, 16'hFFFF};
        vecs[5] = '{24'h800000, 16'h0000};
        vecs[6] = '{24'h040000, 16'hFFFF};
        vecs[7] = '{24'h012340, 16'hA468};
        vecs[8] = '{24'hFFF000, 16'h7E00};

        tests = 0; failed = 0; sel = 1'b0;
        reset1 = 1'b1; reset2 = 1'b1; sample1 = '0; sample2 = '0;

        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst sync_n",  32'(syncN1), 32'h1);
        checkOutput("rst sclk",    32'(sclk1),  32'h1);
        checkOutput("rst din",     32'(din1),   32'h0);
        checkOutput("rst word",    32'(word1),  32'h8000);
        checkOutput("rst busy",    32'(busy1),  32'h0);
        checkOutput("rst overrun", 32'(ovr1),   32'h0);
        checkOutput("rst tick",    32'(tick1),  32'h0);

        @(negedge clk);
        reset1 = 1'b0;
        sample1 = vecs[0].sample;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) applyStimulus(vecs[i].sample);
            captureFrame(0, 24'($urandom), bits, lowCycles, waitCycles, tickAt, timedOut);
            checkOutput($sformatf("vec%0d timeout", i), 32'(timedOut), 32'h0);
            if (i == 0) begin
                checkOutput("first tick cycle", 32'(tickAt), 32'd99);
                checkOutput("first frame start", 32'(waitCycles), 32'd100);
            end
            checkOutput($sformatf("vec%0d bits", i), 32'(bits), 32'(vecs[i].word));
            checkOutput($sformatf("vec%0d word", i), 32'(word1), 32'(vecs[i].word));
            checkOutput($sformatf("vec%0d sync low", i), 32'(lowCycles), 32'd64);
            checkOutput($sformatf("vec%0d idle sclk/din/busy", i),
                        {29'd0, sclk1, din1, busy1}, 32'b100);
        end
        checkOutput("main overrun", 32'(ovr1), 32'h0);

        // Reset at the 7th SCLK falling edge, then a clean frame afterwards.
        applyStimulus(24'h012340);
        captureFrame(7, 24'h012340, bits, lowCycles, waitCycles, tickAt, timedOut);
        checkOutput("midrst timeout", 32'(timedOut), 32'h0);
        checkOutput("midrst outputs", {27'd0, syncN1, sclk1, busy1, din1, ovr1}, 32'b11000);
        checkOutput("midrst word", 32'(word1), 32'h8000);
        @(negedge clk);
        reset1 = 1'b0;
        sample1 = 24'hFFF000;
        captureFrame(0, 24'($urandom), bits, lowCycles, waitCycles, tickAt, timedOut);
        checkOutput("postrst timeout", 32'(timedOut), 32'h0);
        checkOutput("postrst start", 32'(waitCycles), 32'd100);
        checkOutput("postrst bits", 32'(bits), 32'h7E00);
        checkOutput("postrst word", 32'(word1), 32'h7E00);
        checkOutput("postrst sync low", 32'(lowCycles), 32'd64);

        // Short sample period: the second tick lands mid-frame.
        sel = 1'b1;
        @(negedge clk);
        reset2 = 1'b0;
        sample2 = 24'h012340;
        captureFrame(0, 24'h000008, bits, lowCycles, waitCycles, tickAt, timedOut);
        checkOutput("ovr timeout", 32'(timedOut), 32'h0);
        checkOutput("ovr start", 32'(waitCycles), 32'd40);
        checkOutput("ovr bits", 32'(bits), 32'hA468);
        checkOutput("ovr sync low", 32'(lowCycles), 32'd64);
        checkOutput("ovr word kept", 32'(word2), 32'hA468);
        checkOutput("ovr set", 32'(selOvr), 32'h1);
        captureFrame(0, 24'($urandom), bits, lowCycles, waitCycles, tickAt, timedOut);
        checkOutput("ovr2 timeout", 32'(timedOut), 32'h0);
        checkOutput("ovr2 start", 32'(waitCycles), 32'd16);
        checkOutput("ovr2 bits", 32'(bits), 32'h8001);
        checkOutput("ovr2 word", 32'(selWord), 32'h8001);
        checkOutput("ovr sticky", 32'(selOvr), 32'h1);
        checkOutput("ovr2 busy", 32'(selBusy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dac_serializer.md
Name: dac_serializer

Overview:
- Output stage directly downstream of voice_controller; consumes its signed 24-bit o_mixed_sample.
- Generates the audio sample-rate tick.
- Converts the sample to a saturated 16-bit offset-binary DAC code and shifts it MSB-first to a serial 16-bit DAC using SCLK/SYNC_n/DIN.
- This replaces the unsaturated "mixed_sample[18:3] + 32768" mapping.

Parameters:
SAMPLE_DIV, 1000, i_clk cycles per audio sample; must be at least 32*SCLK_DIV+2.
SCLK_DIV, 2, i_clk cycles per SCLK half-period; must be at least 1.
SHIFT, 3, arithmetic right shift applied to the 24-bit sample before saturation to 16 bits.

Ports:
i_clk  in  1  system clock; all logic on its rising edge.
i_reset  in  1  synchronous, active-high reset.
i_sample  in  24  signed mixed sample from voice_controller (o_mixed_sample).
o_sample_tick  out  1  one-cycle pulse per sample period; the capture point for i_sample.
o_dac_word  out  16  last converted offset-binary code (debug/monitor).
o_dac_sclk  out  1  serial clock; idle high.
o_dac_sync_n  out  1  frame select, active low.
o_dac_din  out  1  serial data, MSB first.
o_busy  out  1  high while a frame is being shifted.
o_overrun  out  1  sticky; set when a tick arrives while busy.

Behaviour:
- Reset values (all synchronous): counters 0; state IDLE; o_sample_tick=0; o_dac_word=16'h8000; o_dac_sclk=1; o_dac_sync_n=1; o_dac_din=0; o_busy=0; o_overrun=0.
- Sample counter:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - o_sample_tick=1 for the single cycle in which the count equals SAMPLE_DIV-1.
  - The first tick occurs SAMPLE_DIV cycles after reset deasserts.
  - The counter runs free regardless of FSM state.
- Conversion (combinational, registered at capture):
  - s = i_sample >>> SHIFT, sign-extended.
  - If s > 32767, clamp to 16'sh7FFF; if s < -32768, clamp to 16'sh8000; otherwise take s[15:0].
  - Code = clamped value with MSB inverted (i.e. + 32768 modulo 2^16).
- FSM states:
  - IDLE: on tick, in the same edge, latch the code into o_dac_word and the shift register, then go to SHIFT.
  - SHIFT: on the edge after the tick:
    - o_dac_sync_n=0, o_busy=1, o_dac_din=code[15], o_dac_sclk=1.
    - o_dac_sclk toggles every SCLK_DIV cycles. On each falling edge the DAC captures din.
    - On each rising edge except the last, din advances to the next lower bit.
    - After 16 falling edges and the final high phase (32*SCLK_DIV cycles total with sync_n low), go to IDLE.
  - IDLE entry: sync_n=1, busy=0, din=0, sclk=1.
  - A new frame may start on any tick seen in IDLE. There is at least one sync_n-high cycle between frames by the parameter constraint.
- Tick while in SHIFT (parameter misconfiguration):
  - The sample is dropped and o_dac_word is unchanged.
  - o_overrun sets and stays set until reset.
  - The current frame completes unaffected.
- i_sample is sampled only on the tick cycle; changes at other times are ignored.
- Reset mid-frame: outputs return to reset values on the next edge. No partial frame is resumed; the next frame starts on the next tick after reset.
- Tick coincident with reset: reset wins.

Test Plan:
- Reset, then hold for 5 cycles -> sync_n=1, sclk=1, din=0, o_dac_word=16'h8000, busy=0, overrun=0. First tick occurs exactly SAMPLE_DIV cycles after reset release.
- i_sample=24'h000000 -> o_dac_word=16'h8000. The bench samples din on 16 sclk falling edges and receives 1000000000000000. sync_n is low for exactly 64 cycles (SCLK_DIV=2).
- i_sample=24'h03FFF8 -> 16'hFFFF. i_sample=24'hFFFFF8 (-8) -> 16'h7FFF. i_sample=24'h000008 -> 16'h8001.
- Saturation: i_sample=24'h7FFFFF -> 16'hFFFF. i_sample=24'h800000 -> 16'h0000. i_sample=24'h040000 -> 16'hFFFF, not wrapped.
- Run with SAMPLE_DIV=40, SCLK_DIV=2 -> overrun sets on the second tick, the first frame completes with all 16 bits, o_dac_word keeps the first code, and overrun stays set.
- Assert i_reset for 1 cycle at the 7th falling sclk of a frame -> next edge gives sync_n=1, sclk=1, busy=0. The next frame, on the following tick, carries the correct new sample with all 16 bits.
